// File: rtl/ahb_frame_reader.sv
// Read-only AHB master: fetches in_len consecutive words from in_src_addr into a FIFO and streams them out.
// Optional macro AHB_FRAME_READER_IRQ_WAIT_EN holds the first read until in_interrupt is seen high.
module ahb_frame_reader #(
   parameter int unsigned FIFO_DEPTH = 8,
   parameter logic [31:0] IDLE_ADDR  = 32'hF000_0000
) (
   input  logic        in_HCLK,
   input  logic        in_HRESET,
   input  logic        in_start,
   input  logic [31:0] in_src_addr,
   input  logic [15:0] in_len,
   input  logic        in_interrupt,
   input  logic        in_HREADY,
   input  logic [31:0] in_HRDATA,
   output logic [31:0] out_HADDR,
   output logic        out_HWRITE,
   output logic [31:0] out_HWDATA,
   output logic [31:0] out_data,
   output logic        out_valid,
   input  logic        in_ready,
   output logic        out_busy,
   output logic        out_done
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      WAIT_IRQ = 3'd1,
      READ     = 3'd2,
      DRAIN    = 3'd3,
      DONE     = 3'd4
   } state_t;

   state_t        state_r;
   logic [31:0]   haddr_r;
   logic          addr_vld_r;
   logic [31:0]   next_addr_r;
   logic [15:0]   rem_r;
   logic          busy_r;
   logic          done_r;
   logic          armed_r;
   logic          outst_r;
   logic [CW-1:0] count_r;
   logic [AW-1:0] wr_ptr_r;
   logic [AW-1:0] rd_ptr_r;
   logic [31:0]   mem_r [FIFO_DEPTH];
   logic          valid_r;
   logic [31:0]   data_r;

   logic          accept_s;
   logic          push_s;
   logic          pop_s;
   logic [CW-1:0] count_nxt_s;
   logic          outst_nxt_s;
   logic [15:0]   rem_nxt_s;
   logic [31:0]   addr_nxt_s;
   logic          room_s;
   logic [AW-1:0] rd_nxt_s;
   logic [31:0]   head_nxt_s;

`ifndef AHB_FRAME_READER_IRQ_WAIT_EN
   logic unused_s;
   assign unused_s = in_interrupt;
`endif

   // Next-cycle view of the bus handshake and FIFO occupancy, shared by the FSM and the FIFO.
   always_comb begin
      accept_s    = (state_r == READ) && addr_vld_r && in_HREADY;
      push_s      = outst_r && in_HREADY;
      pop_s       = valid_r && in_ready;
      count_nxt_s = count_r + CW'(push_s) - CW'(pop_s);
      outst_nxt_s = accept_s | (outst_r & ~push_s);
      rem_nxt_s   = accept_s ? rem_r - 16'd1 : rem_r;
      addr_nxt_s  = accept_s ? next_addr_r + 32'd4 : next_addr_r;
      // Words in flight count against FIFO space so a capture can never find it full.
      room_s      = (count_nxt_s + CW'(outst_nxt_s)) < DEPTH_C;
      rd_nxt_s    = pop_s ? rd_ptr_r + AW'(1'b1) : rd_ptr_r;
      if (push_s && ((count_r - CW'(pop_s)) == {CW{1'b0}})) begin
         head_nxt_s = in_HRDATA;
      end else begin
         head_nxt_s = mem_r[rd_nxt_s];
      end
   end

   // Command FSM and registered address phase.
   always_ff @(posedge in_HCLK or negedge in_HRESET) begin
      if (!in_HRESET) begin
         state_r     <= IDLE;
         haddr_r     <= IDLE_ADDR;
         addr_vld_r  <= 1'b0;
         next_addr_r <= 32'h0000_0000;
         rem_r       <= 16'd0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         armed_r     <= 1'b0;
      end else begin
         done_r  <= 1'b0;
         armed_r <= 1'b1;
         case (state_r)
            IDLE: begin
               if (in_start && armed_r) begin
                  busy_r      <= 1'b1;
                  next_addr_r <= in_src_addr;
                  rem_r       <= in_len;
                  if (in_len == 16'd0) begin
                     state_r <= DONE;
                  end else begin
`ifdef AHB_FRAME_READER_IRQ_WAIT_EN
                     state_r <= WAIT_IRQ;
`else
                     state_r <= READ;
                     if (in_HREADY) begin
                        haddr_r    <= in_src_addr;
                        addr_vld_r <= 1'b1;
                     end
`endif
                  end
               end
            end
`ifdef AHB_FRAME_READER_IRQ_WAIT_EN
            WAIT_IRQ: begin
               if (in_interrupt) begin
                  state_r <= READ;
                  if (in_HREADY) begin
                     haddr_r    <= next_addr_r;
                     addr_vld_r <= 1'b1;
                  end
               end
            end
`endif
            READ: begin
               next_addr_r <= addr_nxt_s;
               rem_r       <= rem_nxt_s;
               // The address (real or idle) only moves on an edge where the bus is ready.
               if (in_HREADY) begin
                  if ((rem_nxt_s != 16'd0) && room_s) begin
                     haddr_r    <= addr_nxt_s;
                     addr_vld_r <= 1'b1;
                  end else begin
                     haddr_r    <= IDLE_ADDR;
                     addr_vld_r <= 1'b0;
                  end
               end
               if (rem_nxt_s == 16'd0) begin
                  state_r <= DRAIN;
               end
            end
            DRAIN: begin
               if (!outst_r && (count_r == {CW{1'b0}})) begin
                  state_r <= DONE;
               end
            end
            DONE: begin
               done_r  <= 1'b1;
               busy_r  <= 1'b0;
               state_r <= IDLE;
            end
            default: begin
               state_r    <= IDLE;
               haddr_r    <= IDLE_ADDR;
               addr_vld_r <= 1'b0;
               busy_r     <= 1'b0;
            end
         endcase
      end
   end

   // FIFO pointers, occupancy, outstanding data phase and registered stream head.
   always_ff @(posedge in_HCLK or negedge in_HRESET) begin
      if (!in_HRESET) begin
         outst_r  <= 1'b0;
         count_r  <= {CW{1'b0}};
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         valid_r  <= 1'b0;
         data_r   <= 32'h0000_0000;
      end else begin
         outst_r  <= outst_nxt_s;
         count_r  <= count_nxt_s;
         rd_ptr_r <= rd_nxt_s;
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1'b1);
         end
         valid_r  <= (count_nxt_s != {CW{1'b0}});
         data_r   <= head_nxt_s;
      end
   end

   // FIFO storage.
   always_ff @(posedge in_HCLK) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= in_HRDATA;
      end
   end

   assign out_HADDR  = haddr_r;
   assign out_HWRITE = 1'b0;
   assign out_HWDATA = 32'h0000_0000;
   assign out_data   = data_r;
   assign out_valid  = valid_r;
   assign out_busy   = busy_r;
   assign out_done   = done_r;

endmodule
